// File: rtl/fpu_pkg.sv
// Shared definitions for the sequential floating-point adder/subtractor:
// one-hot status codes, FSM state encoding and format width helpers.
package fpu_pkg;

  // One-hot status, MSB..LSB = {INEXACT, UNDERFLOW, OVERFLOW, EXACT}
  localparam logic [3:0] ST_INEXACT   = 4'b1000;
  localparam logic [3:0] ST_UNDERFLOW = 4'b0100;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0010;
  localparam logic [3:0] ST_EXACT     = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  function automatic int fpu_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fpu_word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fpu_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fpu_unpack.sv
// Splits a sign|exponent|mantissa word into fields, restores the hidden bit
// and classifies the operand as zero (exponent 0) or special (exponent all-ones).
module fpu_unpack
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = fpu_word_w(EXP_W, MAN_W)
) (
  input  logic [W-1:0]     i_word,
  output logic             o_sign,
  output logic [EXP_W-1:0] o_exp,
  output logic [MAN_W:0]   o_man,
  output logic             o_zero,
  output logic             o_special
);

  logic [MAN_W-1:0] w_frac;

  assign o_sign    = i_word[W-1];
  assign o_exp     = i_word[W-2:MAN_W];
  assign w_frac    = i_word[MAN_W-1:0];
  assign o_zero    = (o_exp == '0);
  assign o_special = &o_exp;
  // No denormals: a zero exponent means the whole value is zero.
  assign o_man     = o_zero ? '0 : {1'b1, w_frac};

endmodule

// File: rtl/fpu_addsub_seq.sv
// Multicycle floating-point adder/subtractor with valid/ready handshakes.
// Alignment and normalisation shift one bit per cycle; rounding is truncation.
module fpu_addsub_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = fpu_word_w(EXP_W, MAN_W)
) (
  input  logic         clock_100Khz,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] Op_A_in,
  input  logic [W-1:0] Op_B_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out
);

  // Working mantissa: carry | hidden | MAN_W | guard | round | sticky
  localparam int WM = MAN_W + 5;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] L_EMAX     = EW'(fpu_exp_max(EXP_W));
  localparam logic signed [EW-1:0] L_ONE      = EW'(1);
  localparam logic signed [EW-1:0] L_ZERO     = '0;
  localparam logic [EXP_W-1:0]     L_COLLAPSE = EXP_W'(MAN_W + 3);

  function automatic logic [WM-1:0] sticky_shr(input logic [WM-1:0] m);
    return {1'b0, m[WM-1:2], m[1] | m[0]};
  endfunction

  // Packs {status, word}; saturates to infinity or flushes to zero on range limits.
  function automatic logic [W+3:0] round_pack(input logic s,
                                              input logic signed [EW-1:0] e,
                                              input logic [WM-1:0] m);
    if (e >= L_EMAX)
      return {ST_OVERFLOW, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e <= L_ZERO)
      return {ST_UNDERFLOW, {W{1'b0}}};
    else
      return {((|m[2:0]) ? ST_INEXACT : ST_EXACT), s, e[EXP_W-1:0], m[WM-3:3]};
  endfunction

  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [W-1:0]           r_data;
  logic [3:0]             r_status;
  logic                   r_sign;
  logic                   r_eff_sub;
  logic signed [EW-1:0]   r_exp;
  logic [EXP_W-1:0]       r_diff;
  logic [WM-1:0]          r_ma;
  logic [WM-1:0]          r_mb;

  logic                   w_sa, w_sb_raw, w_sb;
  logic [EXP_W-1:0]       w_ea, w_eb, w_el, w_es;
  logic [MAN_W:0]         w_ma, w_mb, w_ml, w_ms;
  logic                   w_za, w_zb, w_spa, w_spb;
  logic                   w_accept, w_swap, w_special, w_inf_sign;
  logic                   w_collapse, w_carry, w_hidden, w_uflow_norm;
  logic [WM-1:0]          w_sum;
  logic [W+3:0]           w_round;

  fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .i_word(Op_A_in), .o_sign(w_sa), .o_exp(w_ea), .o_man(w_ma),
    .o_zero(w_za), .o_special(w_spa)
  );

  fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .i_word(Op_B_in), .o_sign(w_sb_raw), .o_exp(w_eb), .o_man(w_mb),
    .o_zero(w_zb), .o_special(w_spb)
  );

  // Subtraction is addition with B's sign flipped.
  assign w_sb       = w_sb_raw ^ op_sub;
  assign w_accept   = in_valid & r_in_ready;
  assign w_swap     = !w_zb && (w_za || ({w_eb, w_mb} > {w_ea, w_ma}));
  assign w_el       = w_swap ? w_eb : w_ea;
  assign w_es       = w_swap ? w_ea : w_eb;
  assign w_ml       = w_swap ? w_mb : w_ma;
  assign w_ms       = w_swap ? w_ma : w_mb;
  assign w_special  = w_spa | w_spb;
  assign w_inf_sign = w_spa ? w_sa : w_sb;

  assign w_collapse   = (r_diff > L_COLLAPSE) || (r_mb == '0);
  assign w_sum        = r_eff_sub ? (r_ma - r_mb) : (r_ma + r_mb);
  assign w_carry      = r_ma[WM-1];
  assign w_hidden     = r_ma[WM-2];
  assign w_uflow_norm = !w_carry && !w_hidden && (r_exp <= L_ONE);
  assign w_round      = round_pack(r_sign, r_exp, r_ma);

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_status    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (w_special) begin
              r_data      <= {w_inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              r_status    <= ST_OVERFLOW;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          if (r_diff == '0 || w_collapse) r_state <= S_ADD;
        end
        S_ADD: begin
          if (w_sum == '0) begin
            r_data      <= '0;
            r_status    <= ST_EXACT;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (w_carry || w_hidden) begin
            r_state <= S_ROUND;
          end else if (w_uflow_norm) begin
            r_data      <= '0;
            r_status    <= ST_UNDERFLOW;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_ROUND: begin
          {r_status, r_data} <= w_round;
          r_out_valid        <= 1'b1;
          r_state            <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture with swap, alignment, add/sub and normalisation.
  always_ff @(posedge clock_100Khz) begin
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          r_sign    <= w_swap ? w_sb : w_sa;
          r_eff_sub <= w_sa ^ w_sb;
          r_exp     <= $signed({2'b00, w_el});
          r_diff    <= w_el - w_es;
          r_ma      <= {1'b0, w_ml, 3'b000};
          r_mb      <= {1'b0, w_ms, 3'b000};
        end
      end
      S_ALIGN: begin
        if (r_diff != '0) begin
          if (w_collapse) begin
            r_mb   <= {{(WM-1){1'b0}}, |r_mb};
            r_diff <= '0;
          end else begin
            r_mb   <= sticky_shr(r_mb);
            r_diff <= r_diff - EXP_W'(1);
          end
        end
      end
      S_ADD: r_ma <= w_sum;
      S_NORM: begin
        if (w_carry) begin
          r_ma  <= sticky_shr(r_ma);
          r_exp <= r_exp + L_ONE;
        end else if (!w_hidden && !w_uflow_norm) begin
          r_ma  <= r_ma << 1;
          r_exp <= r_exp - L_ONE;
        end
      end
      default: ;
    endcase
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign data_out   = r_data;
  assign status_out = r_status;

endmodule
